calc_key_sequencer: RTL
=======================

Name: calc_key_sequencer

Overview:
- Parametrised successor to the calculator keypad controller: accepts key events from the keypad decoder and tells the calculator memory block where to store data.
- Synchronises and debounces the press, so each physical press yields exactly one action.
- Sequences up to NUM_OPERANDS operands, each separated by an operator, and issues registered one-cycle write, clear, evaluate and error strobes.
- Sits between the keypad decoder and the operand/opcode memory and ALU front end.

Parameters:
- DATA_W, 4: width of key_value and mem_data.
- NUM_OPERANDS, 2: operand slots, legal 2..8; operator slots = NUM_OPERANDS-1.
- DEBOUNCE_CYCLES, 4: consecutive synchronised samples needed to accept a press or release; minimum 1.
- LOC_W, $clog2(2*NUM_OPERANDS): width of mem_loc (derived, do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- key_press  in  1  raw key-down level from the keypad decoder.
- key_type  in  2  00 digit, 01 operator, 10 equal, 11 clear; stable while key_press is high.
- key_value  in  DATA_W  digit or opcode value; stable while key_press is high.
- mem_set  out  1  one-cycle write strobe.
- mem_clr  out  1  one-cycle clear-all strobe.
- mem_loc  out  LOC_W  write slot: 0..NUM_OPERANDS-1 are operands; NUM_OPERANDS+i is operator i.
- mem_data  out  DATA_W  write data, valid with mem_set.
- mem_display  out  LOC_W  operand slot to display.
- eval_req  out  1  one-cycle evaluate strobe.
- operand_count  out  LOC_W  operands entered; valid with eval_req.
- key_err  out  1  one-cycle strobe for an illegal key, which is dropped.

Behaviour:
- Reset: all outputs 0, op_idx=0, digit_seen=0, FSM=WAIT_PRESS, synchroniser and debounce counter cleared. Reset is asynchronous and can abort any state; the next action needs a fresh press.
- Synchroniser: key_press passes through 2 flops; the FSM sees ks.
- FSM states: WAIT_PRESS, DEB_PRESS, ACT, DEB_RELEASE.
- WAIT_PRESS: ks=1 -> DEB_PRESS with cnt=1.
- DEB_PRESS: ks=0 -> WAIT_PRESS with no action. cnt==DEBOUNCE_CYCLES -> ACT. Otherwise cnt++.
- On the ACT entry edge, key_type and key_value are captured and the strobes and data registers are set.
- Strobes are high for exactly the one ACT cycle.
- Latency: count as edge 0 the first edge sampling key_press=1. Strobes are high from edge DEBOUNCE_CYCLES+2 to edge DEBOUNCE_CYCLES+3.
- ACT -> DEB_RELEASE with cnt=0.
- DEB_RELEASE: ks=1 -> cnt=0. ks=0 -> cnt++. cnt==DEBOUNCE_CYCLES -> WAIT_PRESS.
- Holding a key produces no repeat action.
- Digit: mem_set=1, mem_loc=op_idx, mem_data=key_value, mem_display=op_idx, digit_seen=1. A repeated digit overwrites the same slot.
- Operator, when digit_seen=1 and op_idx<NUM_OPERANDS-1: mem_set=1, mem_loc=NUM_OPERANDS+op_idx, mem_data=key_value, then op_idx++ and digit_seen=0.
- Operator, otherwise (no digit yet, or op_idx at the last slot): key_err=1 and nothing is written.
- Equal, when digit_seen=1: eval_req=1, operand_count=op_idx+1, then op_idx=0 and digit_seen=0. mem_display is held.
- Equal, when digit_seen=0: key_err=1 and no eval.
- Clear: mem_clr=1, op_idx=0, digit_seen=0, mem_display=0.
- mem_set, mem_clr, eval_req and key_err are mutually exclusive.
- mem_loc, mem_data and operand_count hold their last values between strobes.

Decomposition:
- calc_pkg holds:
  - key_type_e (KEY_DIGIT, KEY_OP, KEY_EQUAL, KEY_CLEAR);
  - seq_state_e;
  - localparam SYNC_STAGES=2.
- Sub-module key_debounce (sync, counter, press/release FSM) outputs a one-cycle accept pulse.
- calc_key_sequencer holds the op_idx and digit_seen logic and the output registers.

Test Plan:
- DEBOUNCE_CYCLES=4, digit 5 held 20 cycles -> one mem_set, loc=0, data=5, display=0. Strobe high between edges 6 and 7, then no repeat.
- Press glitch 2 cycles high, then low -> no strobe, and FSM returns to WAIT_PRESS.
- Sequence 3, op 1, 7, equal with NUM_OPERANDS=2:
  - writes loc0=3, loc2=1, loc1=7;
  - eval_req with operand_count=2;
  - op_idx returns to 0.
- Key-order errors:
  - operator as first key -> key_err, no mem_set;
  - 3, op, 4, op with NUM_OPERANDS=2 -> key_err on the second op;
  - equal directly after an op -> key_err, no eval_req.
- NUM_OPERANDS=4, sequence 1,op,2,op,3,op,4,equal -> operator slots 4,5,6 written, operand_count=4. A further op before equal -> key_err.
- Reset and clear:
  - rst mid-DEB_PRESS, key held -> all outputs 0, and an action needs release plus a new press;
  - clear after 2 operands -> mem_clr pulse, display=0, next digit goes to loc 0.

Source files
------------

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the calculator key sequencer.
//   key_type_e  : decoded key class carried on key_type
//   seq_state_e : press/release debounce FSM state encoding
//   SYNC_STAGES : depth of the key_press synchroniser
// ---------------------------------------------------------------------------
package calc_pkg;

  typedef enum logic [1:0] {
    KEY_DIGIT = 2'b00,
    KEY_OP    = 2'b01,
    KEY_EQUAL = 2'b10,
    KEY_CLEAR = 2'b11
  } key_type_e;

  // State encoding kept as plain constants so older blocks can reuse it.
  typedef logic [1:0] seq_state_e;
  localparam seq_state_e ST_WAIT_PRESS  = 2'd0;
  localparam seq_state_e ST_DEB_PRESS   = 2'd1;
  localparam seq_state_e ST_ACT         = 2'd2;
  localparam seq_state_e ST_DEB_RELEASE = 2'd3;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronises the raw key-down level and debounces both press and release,
// producing exactly one accept pulse per physical press.
//   clk, rst   : clock and asynchronous active-high reset
//   key_press  : raw key-down level (asynchronous to clk)
//   accept     : high for the single cycle whose closing edge enters ACT
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_press,
  output logic accept
);
  import calc_pkg::*;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [SYNC_STAGES-1:0] vld_r;
  logic                   ks_s;
  logic                   armed_r;
  seq_state_e             state_r;
  seq_state_e             state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   accept_s;

  assign ks_s   = sync_r[SYNC_STAGES-1];
  assign accept = accept_s;

  // Synchroniser plus a validity shadow; armed_r only sets once a genuine
  // released level has been seen, so a key held through reset is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r  <= '0;
      vld_r   <= '0;
      armed_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], key_press};
      vld_r   <= {vld_r[SYNC_STAGES-2:0], 1'b1};
      armed_r <= armed_r | (vld_r[SYNC_STAGES-1] & ~ks_s);
    end
  end

  // Press/release FSM next-state and counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_WAIT_PRESS: begin
        if (ks_s && armed_r) begin
          state_nxt_s = ST_DEB_PRESS;
          cnt_nxt_s   = CNT_W'(1);
        end else begin
          state_nxt_s = ST_WAIT_PRESS;
          cnt_nxt_s   = '0;
        end
      end
      ST_DEB_PRESS: begin
        if (!ks_s) begin
          state_nxt_s = ST_WAIT_PRESS;
          cnt_nxt_s   = '0;
        end else if (cnt_r == CNT_MAX) begin
          state_nxt_s = ST_ACT;
          cnt_nxt_s   = '0;
          accept_s    = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_ACT: begin
        state_nxt_s = ST_DEB_RELEASE;
        cnt_nxt_s   = '0;
      end
      ST_DEB_RELEASE: begin
        // Any bounce back to pressed restarts the release count.
        if (ks_s) begin
          cnt_nxt_s   = '0;
        end else if (cnt_r == CNT_MAX) begin
          state_nxt_s = ST_WAIT_PRESS;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_WAIT_PRESS;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // FSM state and debounce counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_WAIT_PRESS;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/calc_key_sequencer.sv
// ---------------------------------------------------------------------------
// calc_key_sequencer
// Turns debounced keypad events into operand/opcode memory writes, clear,
// evaluate and error strobes. All outputs are registered.
//   clk, rst       : clock and asynchronous active-high reset
//   key_press      : raw key-down level
//   key_type       : 00 digit, 01 operator, 10 equal, 11 clear
//   key_value      : digit or opcode value
//   mem_set        : one-cycle write strobe (mem_loc/mem_data valid)
//   mem_clr        : one-cycle clear-all strobe
//   mem_loc        : write slot, operands 0..N-1, operator i at N+i
//   mem_data       : write data
//   mem_display    : operand slot to display
//   eval_req       : one-cycle evaluate strobe
//   operand_count  : operands entered, valid with eval_req
//   key_err        : one-cycle strobe for a dropped illegal key
// ---------------------------------------------------------------------------
module calc_key_sequencer #(
  parameter int DATA_W          = 4,
  parameter int NUM_OPERANDS    = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOC_W           = $clog2(2 * NUM_OPERANDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_press,
  input  logic [1:0]        key_type,
  input  logic [DATA_W-1:0] key_value,
  output logic              mem_set,
  output logic              mem_clr,
  output logic [LOC_W-1:0]  mem_loc,
  output logic [DATA_W-1:0] mem_data,
  output logic [LOC_W-1:0]  mem_display,
  output logic              eval_req,
  output logic [LOC_W-1:0]  operand_count,
  output logic              key_err
);
  import calc_pkg::*;

  localparam logic [LOC_W-1:0] NUM_OPS_L   = LOC_W'(NUM_OPERANDS);
  localparam logic [LOC_W-1:0] LAST_OP_IDX = LOC_W'(NUM_OPERANDS - 1);

  logic              accept_s;
  logic [LOC_W-1:0]  op_idx_r;
  logic              digit_seen_r;
  logic              mem_set_r;
  logic              mem_clr_r;
  logic [LOC_W-1:0]  mem_loc_r;
  logic [DATA_W-1:0] mem_data_r;
  logic [LOC_W-1:0]  mem_display_r;
  logic              eval_req_r;
  logic [LOC_W-1:0]  operand_count_r;
  logic              key_err_r;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .key_press(key_press),
    .accept   (accept_s)
  );

  assign mem_set       = mem_set_r;
  assign mem_clr       = mem_clr_r;
  assign mem_loc       = mem_loc_r;
  assign mem_data      = mem_data_r;
  assign mem_display   = mem_display_r;
  assign eval_req      = eval_req_r;
  assign operand_count = operand_count_r;
  assign key_err       = key_err_r;

  // Operand sequencing and output registers; key fields are sampled on the
  // accept edge, and strobes fall again on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_idx_r        <= '0;
      digit_seen_r    <= 1'b0;
      mem_set_r       <= 1'b0;
      mem_clr_r       <= 1'b0;
      mem_loc_r       <= '0;
      mem_data_r      <= '0;
      mem_display_r   <= '0;
      eval_req_r      <= 1'b0;
      operand_count_r <= '0;
      key_err_r       <= 1'b0;
    end else begin
      mem_set_r  <= 1'b0;
      mem_clr_r  <= 1'b0;
      eval_req_r <= 1'b0;
      key_err_r  <= 1'b0;
      if (accept_s) begin
        case (key_type_e'(key_type))
          KEY_DIGIT: begin
            mem_set_r     <= 1'b1;
            mem_loc_r     <= op_idx_r;
            mem_data_r    <= key_value;
            mem_display_r <= op_idx_r;
            digit_seen_r  <= 1'b1;
          end
          KEY_OP: begin
            if (digit_seen_r && (op_idx_r < LAST_OP_IDX)) begin
              mem_set_r    <= 1'b1;
              mem_loc_r    <= NUM_OPS_L + op_idx_r;
              mem_data_r   <= key_value;
              op_idx_r     <= op_idx_r + LOC_W'(1);
              digit_seen_r <= 1'b0;
            end else begin
              key_err_r    <= 1'b1;
            end
          end
          KEY_EQUAL: begin
            if (digit_seen_r) begin
              eval_req_r      <= 1'b1;
              operand_count_r <= op_idx_r + LOC_W'(1);
              op_idx_r        <= '0;
              digit_seen_r    <= 1'b0;
            end else begin
              key_err_r       <= 1'b1;
            end
          end
          KEY_CLEAR: begin
            mem_clr_r     <= 1'b1;
            op_idx_r      <= '0;
            digit_seen_r  <= 1'b0;
            mem_display_r <= '0;
          end
          default: begin
            key_err_r <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
